// File: rtl/keyboard_pkg.sv
// Shared constants, FSM state type and helpers for the digit-keyboard debouncer.
package keyboard_pkg;

   localparam int KEY_W                   = 10;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int DEFAULT_REPEAT_CYCLES   = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } key_state_t;

   // A press is only a candidate when exactly one digit line is active.
   function automatic logic is_one_hot(input logic [KEY_W-1:0] keys);
      return $onehot(keys);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous input lines; output lags the input by two clocks.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keyboard_debounce.sv
// Debounces ten raw digit-key lines into a registered one-hot key plus a press strobe.
// Defining KEY_REPEAT_EN adds auto-repeat strobes while a key stays pressed.
module keyboard_debounce
   import keyboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] key_raw,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             key_busy
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255) || (REPEAT_CYCLES < 1)) begin : g_bad_params
         $error("keyboard_debounce: DEBOUNCE_CYCLES must be 1..255 and REPEAT_CYCLES at least 1");
      end
   endgenerate

   logic [KEY_W-1:0] key_sync;
   key_state_t       state_q, state_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] key_out_d;
   logic             key_valid_d;

`ifdef KEY_REPEAT_EN
   localparam int              REP_W    = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

   sync_2ff #(
      .WIDTH (KEY_W)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_raw),
      .q     (key_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cand_q    <= '0;
         cnt_q     <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         key_out   <= key_out_d;
         key_valid <= key_valid_d;
`ifdef KEY_REPEAT_EN
         rep_cnt_q <= rep_cnt_d;
`endif
      end
   end

   // Once a key is accepted, any change (even to another single key) must be
   // followed by a full quiet period before the next press can start.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_out_d   = key_out;
      key_valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (is_one_hot(key_sync)) begin
               cand_d  = key_sync;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (key_sync != cand_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = PRESSED;
               key_out_d   = cand_q;
               key_valid_d = 1'b1;
`ifdef KEY_REPEAT_EN
               rep_cnt_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (key_sync != cand_q) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
`ifdef KEY_REPEAT_EN
            else if (rep_cnt_q == REP_LAST) begin
               key_valid_d = 1'b1;
               rep_cnt_d   = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
`endif
         end
         RELEASE: begin
            if (key_sync != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               key_out_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      key_busy = (state_q != IDLE);
   end

endmodule

// File: tb/tb_keyboard_debounce.sv
// Self-checking bench for keyboard_debounce: vector table, reset sequences and random keys
// against a behavioural model; expectations follow KEY_REPEAT_EN when it is defined.
module tb_keyboard_debounce;
   import keyboard_pkg::*;

   localparam int DEB = 4;
   localparam int REP = 8;
`ifdef KEY_REPEAT_EN
   localparam bit REPEAT_ON   = 1'b1;
   localparam int P_LONG_008  = 2;
   localparam int P_HOLD_200  = 4;
`else
   localparam bit REPEAT_ON   = 1'b0;
   localparam int P_LONG_008  = 1;
   localparam int P_HOLD_200  = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [KEY_W-1:0] key_raw = '0;
   logic [KEY_W-1:0] key_out;
   logic             key_valid;
   logic             key_busy;

   keyboard_debounce #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_raw   (key_raw),
      .key_out   (key_out),
      .key_valid (key_valid),
      .key_busy  (key_busy)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int pulse_cnt = 0;

   typedef struct {
      logic [KEY_W-1:0] raw;
      int               cycles;
      bit               check_end;
      logic [KEY_W-1:0] exp_out;
      bit               exp_busy;
      int               exp_pulses;
   } vec_t;

   vec_t vecs[$];

   // Behavioural model: a press is a one-hot value seen DEB+1 samples in a row,
   // a release is DEB consecutive all-zero samples after the held key changed.
   logic [KEY_W-1:0] m_s1, m_s2, m_cand, m_key, m_out;
   int               m_stable, m_zeros, m_since;
   bit               m_held, m_releasing, m_valid;

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; m_cand = '0; m_key = '0; m_out = '0;
      m_stable = 0; m_zeros = 0; m_since = 0;
      m_held = 1'b0; m_releasing = 1'b0; m_valid = 1'b0;
   endtask

   task automatic model_edge(input logic [KEY_W-1:0] raw_now);
      logic [KEY_W-1:0] s;
      if (!rst_n) begin
         model_clear();
      end else begin
         s = m_s2;
         m_valid = 1'b0;
         if (m_held) begin
            if (!m_releasing) begin
               if (s != m_key) begin
                  m_releasing = 1'b1;
                  m_zeros = 0;
               end else if (REPEAT_ON) begin
                  m_since++;
                  if (m_since == REP) begin
                     m_valid = 1'b1;
                     m_since = 0;
                  end
               end
            end else if (s == '0) begin
               m_zeros++;
               if (m_zeros == DEB) begin
                  m_held = 1'b0;
                  m_releasing = 1'b0;
                  m_out = '0;
               end
            end else begin
               m_zeros = 0;
            end
         end else if (m_cand == '0) begin
            if ($countones(s) == 1) begin
               m_cand = s;
               m_stable = 1;
            end
         end else if (s == m_cand) begin
            m_stable++;
            if (m_stable == DEB + 1) begin
               m_held = 1'b1;
               m_key = m_cand;
               m_cand = '0;
               m_out = m_key;
               m_valid = 1'b1;
               m_since = 0;
            end
         end else begin
            m_cand = '0;
         end
         m_s2 = m_s1;
         m_s1 = raw_now;
      end
   endtask

   task automatic check_output(input string name, input logic [KEY_W-1:0] actual,
                               input logic [KEY_W-1:0] expected);
      check_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
   endtask

   task automatic check_count(input string name, input int actual, input int expected);
      check_cnt++;
      if (actual == expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
   endtask

   task automatic apply_stimulus(input logic [KEY_W-1:0] raw, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         key_raw = raw;
         @(posedge clk);
         model_edge(raw);
         #1;
         check_output("model_key_out", key_out, m_out);
         check_output("model_key_valid", KEY_W'(key_valid), KEY_W'(m_valid));
         check_output("model_key_busy", KEY_W'(key_busy), KEY_W'((m_cand != '0) || m_held));
         if (key_valid) pulse_cnt++;
      end
   endtask

   task automatic reset_and_restrobe(input string tag);
      rst_n = 1'b0;
      model_clear();
      #1;
      check_output({tag, "_out"}, key_out, '0);
      check_output({tag, "_valid"}, KEY_W'(key_valid), '0);
      check_output({tag, "_busy"}, KEY_W'(key_busy), '0);
      apply_stimulus(10'h001, 2);
      #2;
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         apply_stimulus(10'h001, 1);
         check_output({tag, "_restrobe"}, KEY_W'(key_valid), KEY_W'(e == 7));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      model_clear();
      rst_n = 1'b0;
      apply_stimulus('0, 3);
      check_output("reset_out", key_out, '0);
      check_output("reset_valid", KEY_W'(key_valid), '0);
      check_output("reset_busy", KEY_W'(key_busy), '0);
      #2;
      rst_n = 1'b1;

      vecs.push_back('{10'h008, 20, 1'b1, 10'h008, 1'b1, P_LONG_008});
      vecs.push_back('{10'h000,  7, 1'b1, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h010,  2, 1'b0, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h000,  2, 1'b0, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h010,  2, 1'b0, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h000,  2, 1'b0, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h010,  2, 1'b0, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h010, 12, 1'b1, 10'h010, 1'b1, 1});
      vecs.push_back('{10'h000,  7, 1'b1, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h003, 20, 1'b1, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h004,  3, 1'b0, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h000,  7, 1'b1, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h001, 12, 1'b1, 10'h001, 1'b1, 1});
      vecs.push_back('{10'h002, 10, 1'b1, 10'h001, 1'b1, 0});
      vecs.push_back('{10'h000,  3, 1'b1, 10'h001, 1'b1, 0});
      vecs.push_back('{10'h000,  4, 1'b1, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h002, 12, 1'b1, 10'h002, 1'b1, 1});
      vecs.push_back('{10'h000,  7, 1'b1, 10'h000, 1'b0, 0});
      vecs.push_back('{10'h200, 35, 1'b1, 10'h200, 1'b1, P_HOLD_200});
      vecs.push_back('{10'h000,  7, 1'b1, 10'h000, 1'b0, 0});

      foreach (vecs[i]) begin
         pulse_cnt = 0;
         apply_stimulus(vecs[i].raw, vecs[i].cycles);
         check_count($sformatf("vec%0d_pulses", i), pulse_cnt, vecs[i].exp_pulses);
         if (vecs[i].check_end) begin
            check_output($sformatf("vec%0d_out", i), key_out, vecs[i].exp_out);
            check_output($sformatf("vec%0d_busy", i), KEY_W'(key_busy), KEY_W'(vecs[i].exp_busy));
         end
      end

      // Reset while debouncing, then again while the key is accepted and held.
      apply_stimulus(10'h001, 4);
      reset_and_restrobe("rst_debounce");
      apply_stimulus(10'h001, 3);
      reset_and_restrobe("rst_pressed");
      apply_stimulus('0, 7);
      check_output("rst_release_out", key_out, '0);

      for (int s = 0; s < 60; s++) begin
         logic [KEY_W-1:0] pat;
         int               a, b, kind;
         kind = $urandom_range(0, 3);
         a = $urandom_range(0, KEY_W - 1);
         b = (a + 1 + $urandom_range(0, KEY_W - 2)) % KEY_W;
         pat = '0;
         if (kind == 1 || kind == 2) pat[a] = 1'b1;
         else if (kind == 3) begin
            pat[a] = 1'b1;
            pat[b] = 1'b1;
         end
         apply_stimulus(pat, $urandom_range(1, 12));
      end
      apply_stimulus('0, 8);
      check_output("final_out", key_out, '0);
      check_output("final_busy", KEY_W'(key_busy), '0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/keyboard_debounce.md
KEYBOARD_DEBOUNCE -- requirements
Module: keyboard_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles required to accept a press or release (legal range 1..255).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 8, meaning the auto-repeat period in cycles (used only under KEY_REPEAT_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port key_raw, input, 10 bits: asynchronous raw key lines, bit i = digit key i, 1 = pressed.
REQ-006 SHALL have port key_out, output, 10 bits: debounced one-hot key, registered, feeds the XS3 keyboard encoder.
REQ-007 SHALL have port key_valid, output, 1 bit: one-cycle registered strobe per accepted press.
REQ-008 SHALL have port key_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 SHALL pass key_raw through a 2-flop synchroniser; key_sync denotes the second-stage value, with 2-cycle latency.
REQ-010 SHALL implement states IDLE, DEBOUNCE, PRESSED and RELEASE, plus a candidate register cand[9:0] and a counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 In IDLE, if key_sync is exactly one-hot: cand<=key_sync, cnt<=0, go to DEBOUNCE; if key_sync is zero or has ≥2 bits set: stay in IDLE.
REQ-012 In DEBOUNCE, if key_sync≠cand: go to IDLE with no strobe; if key_sync==cand and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, key_out<=cand, key_valid<=1; otherwise cnt<=cnt+1.
REQ-013 In PRESSED, key_out SHALL be held; if key_sync≠cand, including a different single key: go to RELEASE with cnt<=0.
REQ-014 In RELEASE, if key_sync==0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE with key_out<=0; if key_sync==0 otherwise: cnt<=cnt+1; if key_sync≠0: cnt<=0 and stay in RELEASE; a new key SHALL never be accepted before a full release.
REQ-015 Latency: for key_raw stable one-hot from rising edge 1, key_valid SHALL be high in the cycle after edge DEBOUNCE_CYCLES+3; release clears key_out after the same count of edges.
REQ-016 key_valid SHALL be high for exactly one cycle per accepted press, and zero in all other cycles except under REQ-021.
REQ-017 Multi-key patterns SHALL never produce a strobe or a nonzero key_out.

Reset
REQ-018 While rst_n=0: synchroniser flops=0, state=IDLE, cand=0, cnt=0, key_out=0, key_valid=0, key_busy=0, and the repeat counter=0.
REQ-019 Reset asserted mid-operation SHALL abort immediately; a key held through reset deassertion SHALL be re-debounced and SHALL produce a new strobe.

Configuration
REQ-020 Macro KEY_REPEAT_EN SHALL select the auto-repeat feature.
REQ-021 With KEY_REPEAT_EN defined: a repeat counter SHALL clear on entry to PRESSED, and key_valid SHALL pulse again every REPEAT_CYCLES cycles while the state stays PRESSED.
REQ-022 Without KEY_REPEAT_EN: the repeat counter SHALL not exist, and there SHALL be exactly one strobe per press.

Structure
REQ-023 Package keyboard_pkg SHALL hold KEY_W=10, the state enum (IDLE, DEBOUNCE, PRESSED, RELEASE) and the default debounce and repeat constants.
REQ-024 Sub-module sync_2ff, parameterised by width, SHALL implement REQ-009; the FSM, counters and outputs SHALL stay in keyboard_debounce.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-025 Drive key_raw=10'b00_0000_1000 from edge 1 for 20 cycles, then 0 -> key_valid high after edge 7 only, key_out=10'h008 from edge 7, key_out=0 at 7 edges after release.
REQ-026 Drive key_raw=10'h010 toggling every 2 cycles for 10 cycles, then stable -> exactly one key_valid and key_out=10'h010, with no strobe during bouncing.
REQ-027 Drive key_raw=10'b00_0000_0011 for 20 cycles -> key_valid never asserts, key_out=0 and key_busy=0; drive a 3-cycle single-key glitch -> no strobe.
REQ-028 Hold 10'h001 and switch directly to 10'h002 while in PRESSED -> no second strobe until all-zero for 4 cycles; then a fresh press of 10'h002 strobes once.
REQ-029 Assert rst_n=0 in DEBOUNCE and again in PRESSED with the key held -> outputs are 0 immediately; after release of reset, key_valid pulses 7 edges later.
REQ-030 With KEY_REPEAT_EN defined, hold 10'h200 for 35 cycles -> key_valid pulses after edges 7, 15, 23 and 31; without the macro -> one pulse only.
